div_4b: RTL and testbench

- Unsigned integer divider for the ALU datapath: quotient `out` and remainder from dividend `a` and divisor `b`.
- Sequential restoring (shift-subtract) implementation, one quotient bit per clock, with a start/done handshake.
- Default operand width is 4 bits. Results are held stable until the next accepted operation.

---
 rtl/div_4b_pkg.sv | 12 +
 rtl/div_4b_step.sv | 25 ++
 rtl/div_4b.sv | 104 ++++++++++
 tb/tb_div_4b.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/div_4b_pkg.sv
// Shared ALU definitions: divider FSM states and the default datapath width.
package div_4b_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_4b_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   prem,
  input  logic [WIDTH-1:0] dvs,
  input  logic             din,
  output logic [WIDTH:0]   prem_nxt,
  output logic             qbit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvs_ext;

  // The incoming remainder is always below the divisor, so the difference fits WIDTH+1 bits.
  always_comb begin
    shifted  = {prem, din};
    dvs_ext  = {2'b00, dvs};
    qbit     = (shifted >= dvs_ext);
    prem_nxt = qbit ? (WIDTH+1)'(shifted - dvs_ext) : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_4b.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency: done in the cycle after edge k+WIDTH+1 for a start accepted at edge k.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module div_4b
  import div_4b_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, dvs, quo;
  logic [WIDTH:0]   prem, prem_nxt;
  logic             qbit;
  logic             last_iter;

  assign last_iter = (cnt == LAST);

  div_step #(.WIDTH(WIDTH)) u_step (
    .prem     (prem),
    .dvs      (dvs),
    .din      (dvd[WIDTH-1]),
    .prem_nxt (prem_nxt),
    .qbit     (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results only move on the edge into DONE, so they hold across idle periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      quo         <= '0;
      prem        <= '0;
      out         <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd  <= a;
            dvs  <= b;
            quo  <= '0;
            prem <= '0;
            cnt  <= '0;
          end
        end
        RUN: begin
          if (last_iter) begin
            out         <= quo;
            remainder   <= prem[WIDTH-1:0];
            div_by_zero <= (dvs == '0);
          end else begin
            prem <= prem_nxt;
            quo  <= {quo[WIDTH-2:0], qbit};
            dvd  <= {dvd[WIDTH-2:0], 1'b0};
            cnt  <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_4b.sv
// Directed and sweep checks for div_4b: results, fixed latency, busy-start rejection, reset abort.
module tb_div_4b;

  localparam int W   = 4;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] out, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  div_4b #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .out         (out),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle or in its done cycle; returns at the
  // negedge where done is seen, with the cycle count from the accepting edge.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, output int lat);
    bit chained;
    chained = done;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    if (chained) begin
      @(negedge clk);
      check("done_width", done, 0);
    end
    for (int i = 0; i < 4 && busy; i++) @(negedge clk);
    @(negedge clk);
    check("busy_after_accept", busy, 1);
    start = 1'b0;
    a     = ~ta;
    b     = ~tb_v;
    lat   = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int lat;
    do_op(ta, tb_v, lat);
    check({tag, "_lat"}, lat, LAT);
    check({tag, "_out"}, out, eq);
    check({tag, "_rem"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, ez);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int lat;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", out, 0);
    check("rst_rem", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    directed("4div2", 4'd4, 4'd2, 4'd2, 4'd0, 1'b0);
    directed("7div3", 4'd7, 4'd3, 4'd2, 4'd1, 1'b0);
    directed("3div7", 4'd3, 4'd7, 4'd0, 4'd3, 1'b0);
    directed("9div0", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
    directed("5div5", 4'd5, 4'd5, 4'd1, 4'd0, 1'b0);
    directed("15div1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    directed("0div0", 4'd0, 4'd0, 4'd15, 4'd0, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_out", out, 15);
    check("hold_dbz", div_by_zero, 1);

    // A second start during RUN with different operands must be dropped.
    start = 1'b1; a = 4'd7; b = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 4'd12; b = 4'd1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 3; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    check("busy_start_lat", lat, LAT);
    check("busy_start_out", out, 2);
    check("busy_start_rem", remainder, 1);
    @(negedge clk);
    repeat (LAT + 3) begin
      @(negedge clk);
      check("busy_start_no_rerun", busy, 0);
    end

    // Exhaustive sweep, each op started in the done cycle of the previous one.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 1; ib < 16; ib++) begin
        logic [W-1:0] va, vb;
        va = W'(ia);
        vb = W'(ib);
        do_op(va, vb, lat);
        check("sweep_lat", lat, LAT);
        check("sweep_out", out, ia / ib);
        check("sweep_rem", remainder, ia % ib);
        check("sweep_invariant", 32'(out) * 32'(ib) + 32'(remainder), ia);
        check("sweep_rem_lt_b", (32'(remainder) < 32'(ib)) ? 1 : 0, 1);
        check("sweep_dbz", div_by_zero, 0);
      end
    end
    @(negedge clk);
    check("sweep_last_done_width", done, 0);
    @(negedge clk);

    // Reset mid-RUN aborts without a done pulse and clears the results.
    check("pre_abort_out_nonzero", (out != '0) ? 1 : 0, 1);
    start = 1'b1; a = 4'd13; b = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out", out, 0);
    check("abort_rem", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    begin
      int seen;
      seen = 0;
      repeat (LAT + 4) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("abort_no_done", seen, 0);
    end
    directed("after_abort_13div2", 4'd13, 4'd2, 4'd6, 4'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
